// File: rtl/audio_level_meter_pkg.sv
// +----------------------------------------------------------------------------+
// | audio_level_meter_pkg : shared widths, LED threshold exponents, log2 macro |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

`ifndef LOG2
`define LOG2(x) (((x) > 1) ? $clog2(x) : 1)
`endif

package audio_level_meter_pkg;

  // The top LED threshold sits at 2^(SampleWidth-2), one octave below full scale.
  localparam int c_top_exp_offset = 2;

  function automatic int mag_width(input int sample_width);
    return sample_width - 1;
  endfunction

  function automatic int led_exponent(input int k, input int sample_width,
                                      input int led_count, input int step_bits);
    return sample_width - c_top_exp_offset - (led_count - 1 - k) * step_bits;
  endfunction

  function automatic int cnt_width(input int max_count);
    return (max_count < 1) ? 1 : $clog2(max_count + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/audio_level_meter_if.sv
// +----------------------------------------------------------------------------+
// | audio_level_meter_if : sample strobe input and bar/level display outputs   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

interface audio_level_meter_if #(
  parameter int SampleWidth = 24,
  parameter int Channels    = 2,
  parameter int LedCount    = 8
);
  import audio_level_meter_pkg::*;

  logic                                InValid;
  logic [Channels*SampleWidth-1:0]     InData;
  logic [`LOG2(Channels)-1:0]          Sel;
  logic                                DotMode;
  logic [LedCount-1:0]                 Bar;
  logic                                Clip;
  logic [mag_width(SampleWidth)-1:0]   Level;

  modport master (
    output InValid, InData, Sel, DotMode,
    input  Bar, Clip, Level
  );

  modport slave (
    input  InValid, InData, Sel, DotMode,
    output Bar, Clip, Level
  );

endinterface

`default_nettype wire

// File: rtl/level_tracker.sv
// +----------------------------------------------------------------------------+
// | level_tracker : per-channel peak level with attack, hold and decay         |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module level_tracker
  import audio_level_meter_pkg::*;
#(
  parameter int SampleWidth = 24,
  parameter int HoldSamples = 4800,
  parameter int DecayShift  = 6
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic                              valid_i,
  input  logic [SampleWidth-1:0]            sample_i,
  output logic [mag_width(SampleWidth)-1:0] level_o,
  output logic                              clip_o
);

  localparam int c_mw = mag_width(SampleWidth);
  localparam int c_hw = cnt_width(HoldSamples);
  localparam logic [c_mw-1:0] c_one      = c_mw'(1);
  localparam logic [c_hw-1:0] c_hold_max = c_hw'(HoldSamples);
  localparam logic [c_hw-1:0] c_hold_one = c_hw'(1);

  logic [c_mw-1:0] w_low, w_mag, w_shift, w_step, w_decayed;
  logic [c_mw-1:0] level_q, level_d;
  logic [c_hw-1:0] hold_q, hold_d;

  // For negative x, |x| equals -low mod 2^(W-1); low==0 is the most-negative code.
  assign w_low = sample_i[SampleWidth-2:0];
  always_comb begin
    w_mag = w_low;
    if (sample_i[SampleWidth-1]) begin
      w_mag = (w_low == '0) ? '1 : -w_low;
    end
  end

  assign w_shift   = level_q >> DecayShift;
  assign w_step    = (w_shift == '0) ? c_one : w_shift;
  assign w_decayed = level_q - w_step;

  always_comb begin
    level_d = level_q;
    hold_d  = hold_q;
    if (valid_i) begin
      if (w_mag >= level_q) begin
        level_d = w_mag;
        hold_d  = '0;
      end else if (hold_q < c_hold_max) begin
        hold_d = hold_q + c_hold_one;
      end else begin
        level_d = (w_decayed > w_mag) ? w_decayed : w_mag;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      level_q <= '0;
      hold_q  <= '0;
    end else begin
      level_q <= level_d;
      hold_q  <= hold_d;
    end
  end

  assign level_o = level_q;
  assign clip_o  = (w_mag == '1);

endmodule

`default_nettype wire

// File: rtl/audio_level_meter.sv
// +----------------------------------------------------------------------------+
// | audio_level_meter : multi-channel peak meter with log bar graph and clip   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module audio_level_meter
  import audio_level_meter_pkg::*;
#(
  parameter int SampleWidth = 24,
  parameter int Channels    = 2,
  parameter int LedCount    = 8,
  parameter int StepBits    = 2,
  parameter int HoldSamples = 4800,
  parameter int DecayShift  = 6,
  parameter int ClipHold    = 24000
) (
  input logic               Clock,
  input logic               Reset_B,
  audio_level_meter_if.slave bus
);

  localparam int c_mw   = mag_width(SampleWidth);
  localparam int c_selw = `LOG2(Channels);
  localparam int c_cw   = cnt_width(ClipHold);
  localparam logic [c_mw-1:0] c_one       = c_mw'(1);
  localparam logic [c_cw-1:0] c_clip_max  = c_cw'(ClipHold);
  localparam logic [c_cw-1:0] c_clip_one  = c_cw'(1);

  generate
    if ((SampleWidth - 2 < (LedCount - 1) * StepBits) || (Channels < 1)) begin : g_param_check
      $error("audio_level_meter: SampleWidth too small for LedCount/StepBits, or Channels < 1");
    end
  endgenerate

  logic [c_mw-1:0]     w_level [Channels];
  logic [Channels-1:0] w_clip;
  logic [c_mw-1:0]     w_sel_level;
  logic [LedCount-1:0] w_bar_code, w_dot_code;
  logic                w_clip_hit;

  logic [c_selw-1:0]   sel_q;
  logic                dot_q;
  logic [LedCount-1:0] bar_q;
  logic [c_mw-1:0]     level_out_q;
  logic [c_cw-1:0]     clip_cnt_q, clip_cnt_d;

  generate
    for (genvar c = 0; c < Channels; c++) begin : g_chan
      level_tracker #(
        .SampleWidth (SampleWidth),
        .HoldSamples (HoldSamples),
        .DecayShift  (DecayShift)
      ) u_tracker (
        .clk_i    (Clock),
        .rst_ni   (Reset_B),
        .valid_i  (bus.InValid),
        .sample_i (bus.InData[c*SampleWidth +: SampleWidth]),
        .level_o  (w_level[c]),
        .clip_o   (w_clip[c])
      );
    end
  endgenerate

  // Sel/DotMode are registered so a display change lines up with the level pipeline.
  assign w_sel_level = (int'(sel_q) < Channels) ? w_level[sel_q] : w_level[0];

  always_comb begin
    w_bar_code = '0;
    for (int k = 0; k < LedCount; k++) begin
      w_bar_code[k] = (w_sel_level >= (c_one << led_exponent(k, SampleWidth, LedCount, StepBits)));
    end
  end

  // Thresholds rise with k, so the bar code is a thermometer and its top edge is the dot.
  assign w_dot_code = w_bar_code & ~(w_bar_code >> 1);

  assign w_clip_hit = bus.InValid & (|w_clip);

  always_comb begin
    clip_cnt_d = clip_cnt_q;
    if (w_clip_hit) begin
      clip_cnt_d = c_clip_max;
    end else if (bus.InValid && (clip_cnt_q != '0)) begin
      clip_cnt_d = clip_cnt_q - c_clip_one;
    end
  end

  always_ff @(posedge Clock or negedge Reset_B) begin
    if (!Reset_B) begin
      sel_q       <= '0;
      dot_q       <= 1'b0;
      bar_q       <= '0;
      level_out_q <= '0;
      clip_cnt_q  <= '0;
    end else begin
      sel_q       <= bus.Sel;
      dot_q       <= bus.DotMode;
      bar_q       <= dot_q ? w_dot_code : w_bar_code;
      level_out_q <= w_sel_level;
      clip_cnt_q  <= clip_cnt_d;
    end
  end

  assign bus.Bar   = bar_q;
  assign bus.Level = level_out_q;
  assign bus.Clip  = (clip_cnt_q != '0);

endmodule

`default_nettype wire

// File: tb/tb_audio_level_meter.sv
// +----------------------------------------------------------------------------+
// | tb_audio_level_meter : directed vectors checked against a sample-level model|
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_audio_level_meter;

  localparam int  SW   = 24;
  localparam int  CH   = 2;
  localparam int  LC   = 8;
  localparam int  SB   = 2;
  localparam int  HOLD = 4800;
  localparam int  DSH  = 6;
  localparam int  CLIP = 24000;
  localparam longint MAXM = (longint'(1) << (SW - 1)) - 1;

  logic Clock   = 1'b0;
  logic Reset_B = 1'b0;

  audio_level_meter_if #(.SampleWidth(SW), .Channels(CH), .LedCount(LC)) bus ();

  audio_level_meter #(
    .SampleWidth (SW),
    .Channels    (CH),
    .LedCount    (LC),
    .StepBits    (SB),
    .HoldSamples (HOLD),
    .DecayShift  (DSH),
    .ClipHold    (CLIP)
  ) dut (
    .Clock   (Clock),
    .Reset_B (Reset_B),
    .bus     (bus)
  );

  always #5 Clock = ~Clock;

  int n_checks = 0;
  int n_errors = 0;

  longint     m_level [CH];
  int         m_hold  [CH];
  int         m_clip;
  int         m_sel;
  bit         m_dot;
  logic [7:0] e_bar;
  longint     e_level;
  bit         e_clip;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic longint mag_of(input logic [SW-1:0] s);
    longint v;
    v = longint'($signed(s));
    if (v < 0) v = -v;
    if (v > MAXM) v = MAXM;
    return v;
  endfunction

  function automatic logic [7:0] bar_of(input longint lvl, input bit dot);
    logic [7:0] b;
    logic [7:0] d;
    b = '0;
    d = '0;
    for (int k = 0; k < LC; k++) begin
      if (lvl >= (longint'(1) << (SW - 2 - (LC - 1 - k) * SB))) b[k] = 1'b1;
    end
    for (int k = 0; k < LC; k++) begin
      if (b[k]) d = 8'(1) << k;
    end
    return dot ? d : b;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < CH; c++) begin
      m_level[c] = 0;
      m_hold[c]  = 0;
    end
    m_clip  = 0;
    m_sel   = 0;
    m_dot   = 1'b0;
    e_bar   = '0;
    e_level = 0;
    e_clip  = 1'b0;
  endtask

  // One clock: drive inputs, advance the model at the edge, compare at the falling edge.
  task automatic cycle(input bit v, input logic [SW-1:0] d0, input logic [SW-1:0] d1);
    int     chan;
    bit     hit;
    longint mg;
    longint step;
    longint dec;
    bus.InValid = v;
    bus.InData  = {d1, d0};
    @(posedge Clock);
    chan    = (m_sel < CH) ? m_sel : 0;
    e_level = m_level[chan];
    e_bar   = bar_of(e_level, m_dot);
    m_sel   = int'(bus.Sel);
    m_dot   = bus.DotMode;
    if (v) begin
      hit = 1'b0;
      for (int c = 0; c < CH; c++) begin
        mg = mag_of((c == 0) ? d0 : d1);
        if (mg == MAXM) hit = 1'b1;
        if (mg >= m_level[c]) begin
          m_level[c] = mg;
          m_hold[c]  = 0;
        end else if (m_hold[c] < HOLD) begin
          m_hold[c]++;
        end else begin
          step = m_level[c] >> DSH;
          if (step < 1) step = 1;
          dec = m_level[c] - step;
          m_level[c] = (dec > mg) ? dec : mg;
        end
      end
      if (hit) m_clip = CLIP;
      else if (m_clip > 0) m_clip--;
    end
    e_clip = (m_clip > 0);
    @(negedge Clock);
    check("bar",   64'(bus.Bar),   64'(e_bar));
    check("level", 64'(bus.Level), 64'(e_level));
    check("clip",  64'(bus.Clip),  64'(e_clip));
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int     drop;
    int     held;
    bit     mono;
    longint prev;
    bus.InValid = 1'b0;
    bus.InData  = '0;
    bus.Sel     = '0;
    bus.DotMode = 1'b0;
    model_reset();
    repeat (3) @(negedge Clock);
    check("reset_bar",   64'(bus.Bar),   64'h0);
    check("reset_level", 64'(bus.Level), 64'h0);
    check("reset_clip",  64'(bus.Clip),  64'h0);
    #1 Reset_B = 1'b1;
    cycle(0, '0, '0);

    cycle(1, 24'h000100, '0);
    cycle(0, '0, '0);
    check("low_led_bar",   64'(bus.Bar),   64'h01);
    check("low_led_level", 64'(bus.Level), 64'h000100);

    cycle(1, 24'h010000, '0);
    cycle(0, '0, '0);
    check("mid_bar", 64'(bus.Bar), 64'h1F);
    bus.DotMode = 1'b1;
    cycle(0, '0, '0);
    cycle(0, '0, '0);
    check("mid_dot", 64'(bus.Bar), 64'h10);
    bus.DotMode = 1'b0;

    bus.Sel = 1'b1;
    cycle(1, 24'hFFF000, 24'hFF0000);
    cycle(0, '0, '0);
    check("neg_level", 64'(bus.Level), 64'h010000);

    cycle(1, '0, 24'h800000);
    cycle(0, '0, '0);
    check("fullscale_level", 64'(bus.Level), 64'h7FFFFF);
    check("fullscale_bar",   64'(bus.Bar),   64'hFF);
    check("fullscale_clip",  64'(bus.Clip),  64'h1);
    drop = 0;
    for (int i = 1; i <= CLIP + 2000; i++) begin
      cycle(1, '0, '0);
      if (bus.Clip === 1'b0) begin
        drop = i;
        break;
      end
    end
    check("clip_hold_strobes", 64'(drop), 64'd24000);

    bus.Sel = 1'b0;
    cycle(0, '0, '0);
    cycle(1, 24'h400000, '0);
    held = 0;
    for (int i = 0; i < HOLD + 500; i++) begin
      cycle(1, '0, '0);
      if (bus.Level === 23'h400000) held++;
      else break;
    end
    // The attack sample itself plus 4800 held strobes.
    check("hold_strobes",    64'(held),      64'd4801);
    check("first_decay",     64'(bus.Level), 64'h3F0000);
    prev = 64'h3F0000;
    mono = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      cycle(1, '0, '0);
      if (longint'(bus.Level) > prev) mono = 1'b0;
      prev = longint'(bus.Level);
      if (bus.Level === '0) break;
    end
    check("decay_monotonic", 64'(mono),      64'h1);
    check("decay_to_zero",   64'(bus.Level), 64'h0);

    cycle(1, 24'h400000, 24'h800000);
    repeat (HOLD + 10) cycle(1, '0, '0);
    #1 Reset_B = 1'b0;
    #1;
    check("async_reset_bar",   64'(bus.Bar),   64'h0);
    check("async_reset_clip",  64'(bus.Clip),  64'h0);
    check("async_reset_level", 64'(bus.Level), 64'h0);
    model_reset();
    #1 Reset_B = 1'b1;
    cycle(1, 24'h000400, '0);
    cycle(0, '0, '0);
    check("post_reset_bar",   64'(bus.Bar),   64'h03);
    check("post_reset_level", 64'(bus.Level), 64'h000400);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/audio_level_meter.md
AUDIO_LEVEL_METER -- requirements
Module: audio_level_meter

Interface
REQ-001 Parameter SampleWidth, default 24, meaning: bits per signed two's-complement sample.
REQ-002 Parameter Channels, default 2, meaning: number of independently metered channels.
REQ-003 Parameter LedCount, default 8, meaning: number of bar-graph outputs.
REQ-004 Parameter StepBits, default 2, meaning: octave spacing between adjacent LED thresholds.
REQ-005 Parameter HoldSamples, default 4800, meaning: valid samples a peak is held before decay starts.
REQ-006 Parameter DecayShift, default 6, meaning: decay step is level >> DecayShift per valid sample.
REQ-007 Parameter ClipHold, default 24000, meaning: valid samples the Clip output stays high after a clip.
REQ-008 Clock  in  1  single clock, rising edge; all logic is in this domain.
REQ-009 Reset_B  in  1  asynchronous, active-low reset.
REQ-010 InValid  in  1  one-cycle strobe; InData is valid for all channels.
REQ-011 InData  in  Channels*SampleWidth  packed samples; channel c occupies bits [c*SampleWidth +: SampleWidth].
REQ-012 Sel  in  `log2(Channels)  channel shown on Bar; values >= Channels display channel 0.
REQ-013 DotMode  in  1  0 = thermometer bar, 1 = only the highest lit LED.
REQ-014 Bar  out  LedCount  log-scaled level display of the selected channel.
REQ-015 Clip  out  1  any channel clipped within the last ClipHold valid samples.
REQ-016 Level  out  SampleWidth-1  current tracked magnitude of the selected channel.

Function
- REQ-017 Magnitude SHALL be the absolute value saturated to SampleWidth-1 bits; the most-negative input SHALL map to 2^(SampleWidth-1)-1.
- REQ-018 Each channel SHALL hold a level register and a hold counter, updated only on cycles with InValid=1.
- REQ-019 Attack: if magnitude >= level, then level <= magnitude and hold counter <= 0, in the cycle after InValid.
- REQ-020 Hold: if magnitude < level and hold counter < HoldSamples, the level SHALL be kept and the counter incremented; the counter SHALL saturate at HoldSamples.
- REQ-021 Decay: if magnitude < level and counter == HoldSamples, level <= level - max(level >> DecayShift, 1) when level != 0; level SHALL never underflow below magnitude (result = max(decayed, magnitude)).
- REQ-022 Attack SHALL take priority over hold and decay in the same cycle.
- REQ-023 LED k (k = 0..LedCount-1) SHALL be lit in bar mode iff level >= 2^(SampleWidth-2 - (LedCount-1-k)*StepBits).
- REQ-024 In DotMode, Bar SHALL contain only the highest-index lit LED bit of the bar-mode code; all zero if none is lit.
- REQ-025 Bar and Level SHALL be registered: sample strobe at cycle N -> level at N+1 -> Bar/Level valid at N+2.
- REQ-026 A Sel or DotMode change SHALL be reflected on Bar/Level two cycles later, with no effect on channel state.
- REQ-027 Clip SHALL assert at N+1 when any channel's magnitude equals 2^(SampleWidth-1)-1 at strobe N; the clip counter reloads on every clip and Clip SHALL deassert after ClipHold further valid samples without a clip.
- REQ-028 Elaboration SHALL fail if SampleWidth-2 < (LedCount-1)*StepBits or Channels < 1.

Reset
- REQ-029 On Reset_B=0, all levels, hold counters, the clip counter, Bar, Level and Clip SHALL become 0 immediately, regardless of Clock.
- REQ-030 Reset asserted mid-hold or mid-decay SHALL discard all state; the first valid sample after release SHALL behave as an attack from level 0.

Structure
- REQ-031 A shared package/header SHALL hold the `log2 macro, threshold-function constants and the saturated-magnitude width.
- REQ-032 Per-channel tracking (magnitude, level, hold counter, decay) SHALL be a sub-module level_tracker, instantiated Channels times via generate.
- REQ-033 Channel mux, threshold compare, dot encoding and clip timer SHALL reside in audio_level_meter.

Verification (SampleWidth=24, LedCount=8, StepBits=2, Channels=2)
- REQ-034 Channel 0 = 0x000100, Sel=0, DotMode=0 -> Bar=8'b00000001 and Level=0x000100 two cycles after the strobe.
- REQ-035 Channel 0 = 0x010000, DotMode=0 then 1 -> Bar=8'b00011111, then 8'b00010000.
- REQ-036 Channel 1 = 0x800000 -> Level(Sel=1)=0x7FFFFF, Bar=8'hFF, Clip=1; Clip drops exactly ClipHold clip-free strobes later.
- REQ-037 Channel 0 = 0x400000 once, then zeros -> Level=0x400000 for 4800 strobes, then 0x3F0000 on the next strobe, monotonic decay to 0.
- REQ-038 Reset_B pulsed low mid-decay with no Clock edge -> Bar=0, Clip=0 immediately; the next strobe of 0x000400 -> Bar=8'b00000011.
